// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: highway/country intersection Moore FSM; highway green by default,
// timed yellow and all-red hand-over to the country road while its car sensor is active.
module traffic_light_ctrl #(
    parameter int Y2R_DELAY = 3,
    parameter int R2G_DELAY = 2
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       x,
    output logic [1:0] highway_road,
    output logic [1:0] country_road
);
    localparam int MAX_DELAY = (Y2R_DELAY > R2G_DELAY) ? Y2R_DELAY : R2G_DELAY;
    localparam int CW = $clog2(MAX_DELAY + 1);
    localparam logic [1:0] RED = 2'b00, YELLOW = 2'b01, GREEN = 2'b10;
    localparam logic [2:0] S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3, S4 = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cnt_done;

    assign cnt_done = cnt_q == '0;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= S0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter holds remaining dwell minus one; it reloads whenever the state changes.
    always_comb begin
        state_d = S0;
        case (state_q)
            S0:      state_d = x ? S1 : S0;
            S1:      state_d = cnt_done ? S2 : S1;
            S2:      state_d = cnt_done ? S3 : S2;
            S3:      state_d = x ? S3 : S4;
            S4:      state_d = cnt_done ? S0 : S4;
            default: state_d = S0;
        endcase
        cnt_d = cnt_done ? '0 : cnt_q - CW'(1);
        if (state_d != state_q)
            cnt_d = (state_d == S1 || state_d == S4) ? CW'(Y2R_DELAY - 1) :
                    (state_d == S2) ? CW'(R2G_DELAY - 1) : '0;
    end

    always_comb begin
        highway_road = (state_q == S0) ? GREEN : (state_q == S1) ? YELLOW : RED;
        country_road = (state_q == S3) ? GREEN : (state_q == S4) ? YELLOW : RED;
    end
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: directed and random x stimulus checked against a queue-based
// schedule of expected light pairs.
module tb_traffic_light_ctrl;
    localparam int Y2R = 3, R2G = 2;
    localparam logic [3:0] HG = 4'b1000, HY = 4'b0100, AR = 4'b0000, CG = 4'b0010, CY = 4'b0001;

    logic       clk = 1'b0, clear = 1'b0, x = 1'b0;
    logic [1:0] hw, cr;
    int         errors = 0, checks = 0;
    logic [3:0] cur = HG;
    logic [3:0] sched[$];

    traffic_light_ctrl #(.Y2R_DELAY(Y2R), .R2G_DELAY(R2G)) dut (
        .clk(clk), .clear(clear), .x(x), .highway_road(hw), .country_road(cr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected lights are a schedule: each request or release appends the whole phase sequence.
    task automatic model_edge(input logic xs);
        if (sched.size() > 0) cur = sched.pop_front();
        else if (cur == HG && xs) begin
            cur = HY;
            repeat (Y2R - 1) sched.push_back(HY);
            repeat (R2G) sched.push_back(AR);
            sched.push_back(CG);
        end else if (cur == CG && !xs) begin
            cur = CY;
            repeat (Y2R - 1) sched.push_back(CY);
            sched.push_back(HG);
        end
    endtask

    task automatic post_check();
        #1;
        check("lights", {hw, cr}, cur);
        check("safe", 4'((hw != 2'b00 && cr != 2'b00) || hw == 2'b11 || cr == 2'b11), 4'd0);
    endtask

    task automatic cyc(input logic xv);
        @(negedge clk) x = xv;
        @(posedge clk);
        model_edge(x);
        post_check();
    endtask

    task automatic glitch();
        @(negedge clk) x = 1'b1;
        #2 x = 1'b0;
        @(posedge clk);
        model_edge(x);
        post_check();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 clear = 1'b0;
        x = 1'b0;
        #1 check("async_rst", {hw, cr}, HG);
        sched.delete();
        cur = HG;
        repeat (2) @(negedge clk);
        clear = 1'b1;
    endtask

    initial begin
        logic xr;
        #12 check("rst_hold", {hw, cr}, HG);
        @(negedge clk) clear = 1'b1;
        repeat (20) cyc(1'b0);
        glitch();
        repeat (15) cyc(1'b1);
        repeat (20) cyc(1'b0);
        repeat (12) cyc(1'b1);
        cyc(1'b0);
        repeat (8) cyc(1'b1);
        repeat (4) cyc(1'b1);
        cyc(1'b0);
        repeat (Y2R + 3) cyc(1'b0);
        repeat (4) cyc(1'b1);
        do_reset();
        repeat (3) cyc(1'b0);
        repeat (8) cyc(1'b1);
        do_reset();
        repeat (10) cyc(1'b1);
        repeat (8) cyc(1'b0);
        xr = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) xr = ~xr;
            if ($urandom_range(0, 99) == 0) do_reset();
            else cyc(xr);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
